ram_write_back_queue: RTL and testbench

Write-side front end for the dual-read-port register RAM. It buffers write-back requests from the execution pipeline in a small FIFO and drains them, one per cycle, into the RAM's single write port. The RAM returns the old word when a read and a write hit the same address in the same cycle, so this block also provides forwarding lookups. Two lookup ports report whether a pending write covers a read address and supply the newest pending data.

---
 rtl/ram_write_back_queue.sv | 118 +++++++++++
 tb/tb_ram_write_back_queue.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_write_back_queue.sv
// Write-back queue in front of the register RAM's single write port.
// Requests drain FIFO-order, one per cycle, and two lookup ports forward the newest pending data.
module ram_write_back_queue #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    iReqValid,
    output logic                    oReqReady,
    input  logic [ADDR_WIDTH-1:0]   iReqAddress,
    input  logic [DATA_WIDTH-1:0]   iReqData,
    input  logic                    iDrainHold,
    output logic                    oWriteEnable,
    output logic [ADDR_WIDTH-1:0]   oWriteAddress,
    output logic [DATA_WIDTH-1:0]   oWriteData,
    input  logic [ADDR_WIDTH-1:0]   iLookupAddress0,
    input  logic [ADDR_WIDTH-1:0]   iLookupAddress1,
    output logic                    oHit0,
    output logic [DATA_WIDTH-1:0]   oHitData0,
    output logic                    oHit1,
    output logic [DATA_WIDTH-1:0]   oHitData1,
    output logic                    oEmpty,
    output logic [$clog2(DEPTH):0]  oCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic                  w_push;
    logic                  w_pop;

    // Full blocks a push even when a pop frees a slot in the same cycle.
    assign oReqReady = (r_count != FULL_COUNT);
    assign w_push    = iReqValid && oReqReady;
    assign w_pop     = (r_count != '0) && !iDrainHold;
    assign oEmpty    = (r_count == '0);
    assign oCount    = r_count;

    // NOTE: the entry storage is deliberately not reset; an entry is only
    // meaningful when head/count say it is, so clearing it buys nothing.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_addr_mem[r_tail] <= iReqAddress;
            r_data_mem[r_tail] <= iReqData;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side sees the pre-edge value regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            oWriteEnable  <= 1'b0;
            oWriteAddress <= '0;
            oWriteData    <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head        <= r_head + PTR_W'(1);
                oWriteEnable  <= 1'b1;
                oWriteAddress <= r_addr_mem[r_head];
                oWriteData    <= r_data_mem[r_head];
            end else begin
                oWriteEnable  <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan from output stage to oldest to youngest entry; later matches win.
    for (genvar p = 0; p < 2; p++) begin : g_lookup
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_addr = (p == 0) ? iLookupAddress0 : iLookupAddress1;

        // NOTE: both outputs get a default before any condition, so no path
        // leaves them unassigned and no latch is inferred.
        always_comb begin
            w_hit  = 1'b0;
            w_data = '0;
            if (oWriteEnable && (oWriteAddress == w_addr)) begin
                w_hit  = 1'b1;
                w_data = oWriteData;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if ((CNT_W'(k) < r_count) &&
                    (r_addr_mem[r_head + PTR_W'(k)] == w_addr)) begin
                    w_hit  = 1'b1;
                    w_data = r_data_mem[r_head + PTR_W'(k)];
                end
            end
        end
    end

    assign oHit0     = g_lookup[0].w_hit;
    assign oHitData0 = g_lookup[0].w_data;
    assign oHit1     = g_lookup[1].w_hit;
    assign oHitData1 = g_lookup[1].w_data;

endmodule

// File: tb/tb_ram_write_back_queue.sv
// Directed bench for ram_write_back_queue: a model tracks accepted writes in
// a queue, and a negedge monitor checks each RAM write against it in order.
module tb_ram_write_back_queue;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } ent_t;

    logic        Clock;
    logic        Reset;
    logic        iReqValid;
    logic        oReqReady;
    logic [7:0]  iReqAddress;
    logic [15:0] iReqData;
    logic        iDrainHold;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [15:0] oWriteData;
    logic [7:0]  iLookupAddress0;
    logic [7:0]  iLookupAddress1;
    logic        oHit0;
    logic [15:0] oHitData0;
    logic        oHit1;
    logic [15:0] oHitData1;
    logic        oEmpty;
    logic [2:0]  oCount;

    int   n_checks = 0;
    int   n_err    = 0;
    int   mdl_cnt  = 0;
    logic mdl_we   = 1'b0;
    logic mon_en   = 1'b0;
    ent_t sb [$];
    logic [15:0] shadow [256];

    ram_write_back_queue #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(8),
        .DEPTH(4)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .iReqValid(iReqValid),
        .oReqReady(oReqReady),
        .iReqAddress(iReqAddress),
        .iReqData(iReqData),
        .iDrainHold(iDrainHold),
        .oWriteEnable(oWriteEnable),
        .oWriteAddress(oWriteAddress),
        .oWriteData(oWriteData),
        .iLookupAddress0(iLookupAddress0),
        .iLookupAddress1(iLookupAddress1),
        .oHit0(oHit0),
        .oHitData0(oHitData0),
        .oHit1(oHit1),
        .oHitData1(oHitData1),
        .oEmpty(oEmpty),
        .oCount(oCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, return at negedge.
    task automatic step(input logic v, input logic [7:0] a, input logic [15:0] d,
                        input logic h, input logic rst);
        logic push;
        logic pop;
        iReqValid   = v;
        iReqAddress = a;
        iReqData    = d;
        iDrainHold  = h;
        Reset       = rst;
        @(posedge Clock);
        if (rst) begin
            mdl_cnt = 0;
            mdl_we  = 1'b0;
            sb.delete();
        end else begin
            push = v && (mdl_cnt != 4);
            pop  = (mdl_cnt != 0) && !h;
            if (push) sb.push_back('{addr: a, data: d});
            mdl_we  = pop;
            mdl_cnt = mdl_cnt + int'(push) - int'(pop);
        end
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    // Monitor: every RAM write must be the oldest accepted, not-yet-written request.
    always @(negedge Clock) begin
        if (mon_en) begin
            check("count", 32'(oCount), 32'(mdl_cnt));
            check("wr_en", 32'(oWriteEnable), 32'(mdl_we));
            if (oWriteEnable) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL wr_extra: got write %h/%h expected no write at %0t",
                             oWriteAddress, oWriteData, $time);
                end else begin
                    ent_t e;
                    e = sb.pop_front();
                    check("wr_addr", 32'(oWriteAddress), 32'(e.addr));
                    check("wr_data", 32'(oWriteData), 32'(e.data));
                    shadow[oWriteAddress] = oWriteData;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iReqValid       = 1'b0;
        iReqAddress     = '0;
        iReqData        = '0;
        iDrainHold      = 1'b0;
        iLookupAddress0 = 8'hFF;
        iLookupAddress1 = 8'hFE;
        Reset           = 1'b1;

        // Reset for two cycles
        step(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 8'h00, 16'h0000, 1'b0, 1'b1);
        #1;
        check("rst_we",    32'(oWriteEnable), 32'd0);
        check("rst_empty", 32'(oEmpty),       32'd1);
        check("rst_count", 32'(oCount),       32'd0);
        check("rst_ready", 32'(oReqReady),    32'd1);
        check("rst_hit0",  32'(oHit0),        32'd0);
        check("rst_hit1",  32'(oHit1),        32'd0);
        mon_en = 1'b1;

        // Single push: write on the cycle after N+1, forwarding until then
        iLookupAddress0 = 8'h05;
        iLookupAddress1 = 8'h06;
        step(1'b1, 8'h05, 16'h1234, 1'b0, 1'b0);
        #1;
        check("single_hit0_q",  32'(oHit0),     32'd1);
        check("single_data0_q", 32'(oHitData0), 32'h1234);
        check("single_hit1",    32'(oHit1),     32'd0);
        check("single_data1",   32'(oHitData1), 32'h0000);
        idle(1);
        #1;
        check("single_we",      32'(oWriteEnable), 32'd1);
        check("single_hit0_o",  32'(oHit0),        32'd1);
        check("single_data0_o", 32'(oHitData0),    32'h1234);
        check("single_empty",   32'(oEmpty),       32'd1);
        idle(1);
        #1;
        check("single_hit0_done",  32'(oHit0),     32'd0);
        check("single_data0_done", 32'(oHitData0), 32'h0000);

        // Fill under hold, reject a fifth request, then drain in order
        iLookupAddress0 = 8'h02;
        for (int i = 1; i <= 4; i++)
            step(1'b1, 8'(i), 16'(16'h0011 * i), 1'b1, 1'b0);
        #1;
        check("full_count", 32'(oCount),    32'd4);
        check("full_ready", 32'(oReqReady), 32'd0);
        check("full_hit0",  32'(oHit0),     32'd1);
        check("full_data0", 32'(oHitData0), 32'h0022);
        iLookupAddress1 = 8'h09;
        iReqValid       = 1'b1;
        iReqAddress     = 8'h09;
        iReqData        = 16'h9999;
        #1;
        check("offered_not_candidate", 32'(oHit1), 32'd0);
        step(1'b1, 8'h09, 16'h9999, 1'b1, 1'b0);
        #1;
        check("full_reject_count", 32'(oCount), 32'd4);
        idle(4);
        #1;
        check("drain_empty", 32'(oEmpty), 32'd1);
        idle(2);
        #1;
        check("rejected_absent", 32'(oHit1), 32'd0);

        // Same address twice: youngest data wins over older entry and output stage
        iLookupAddress0 = 8'h07;
        step(1'b1, 8'h07, 16'hAAAA, 1'b1, 1'b0);
        step(1'b1, 8'h07, 16'hBBBB, 1'b1, 1'b0);
        #1;
        check("dup_queue_data", 32'(oHitData0), 32'hBBBB);
        idle(1);
        #1;
        check("dup_mixed_hit",  32'(oHit0),     32'd1);
        check("dup_mixed_data", 32'(oHitData0), 32'hBBBB);
        idle(1);
        #1;
        check("dup_out_data", 32'(oHitData0), 32'hBBBB);
        idle(2);
        check("dup_ram_word", 32'(shadow[8'h07]), 32'hBBBB);

        // Random pushes with random hold; pointers wrap several times
        for (int i = 0; i < 12; i++)
            step(1'b1, 8'($urandom_range(16, 127)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        idle(8);
        check("rand_drained", 32'(sb.size()), 32'd0);
        check("rand_empty",   32'(oEmpty),    32'd1);

        // Reset with entries queued and a request offered: everything dropped
        step(1'b1, 8'h21, 16'h2121, 1'b1, 1'b0);
        step(1'b1, 8'h22, 16'h2222, 1'b1, 1'b0);
        step(1'b1, 8'h23, 16'h2323, 1'b1, 1'b0);
        #1;
        check("pre_rst_count", 32'(oCount), 32'd3);
        step(1'b1, 8'h33, 16'h3333, 1'b0, 1'b1);
        #1;
        check("post_rst_count", 32'(oCount),       32'd0);
        check("post_rst_we",    32'(oWriteEnable), 32'd0);
        check("post_rst_empty", 32'(oEmpty),       32'd1);
        idle(4);
        check("post_rst_idle_count", 32'(oCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
